fc_classifier: RTL and testbench

- Final stage of the CNN pipeline, directly downstream of the layer-2 pooled feature memory.
- On `start`, computes one dot product per class: flattened int8 features against int8 weights, plus an int8 bias.
- Streams each class score as it completes, then reports the arg-max class.
- Features, weights and biases come from external synchronous ROM/RAM read ports with 1-cycle read latency.

---
 rtl/fc_classifier.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fc_classifier.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_classifier.sv
`default_nettype none
// ============================================================================
// Module      : fc_classifier
// Description : Fully-connected classifier stage. On start, computes one
//               int8 x int8 dot product per class over the flattened feature
//               vector, adds an int8 bias, streams each class score as it
//               completes and reports the arg-max class at the end.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N_FEAT      - number of flattened features per class
//   NUM_CLASSES - number of output classes (at most 16)
//   ACC_W       - signed accumulator / score width
//   FA_W        - feature address width  (2**FA_W >= N_FEAT)
//   WA_W        - weight address width   (2**WA_W >= N_FEAT*NUM_CLASSES)
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   start               - begin a classification (only sampled while idle)
//   f_addr / f_data     - feature memory read port, 1-cycle read latency
//   w_addr / w_data     - weight memory read port (class*N_FEAT + k)
//   b_addr / b_data     - bias memory read port (class index)
//   busy                - run in progress
//   score_valid         - 1-cycle pulse with score_class / score
//   done                - 1-cycle pulse at the end of a run
//   class_idx           - arg-max class, held until overwritten by a run
//   best_score          - score of class_idx
// Build option:
//   FC_SAT_EN           - when defined, every accumulate saturates to the
//                         signed ACC_W range; otherwise adders wrap.
// ============================================================================
module fc_classifier #(
  parameter int N_FEAT      = 784,
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 24,
  parameter int FA_W        = 10,
  parameter int WA_W        = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [FA_W-1:0]         f_addr,
  input  logic [7:0]              f_data,
  output logic [WA_W-1:0]         w_addr,
  input  logic [7:0]              w_data,
  output logic [3:0]              b_addr,
  input  logic [7:0]              b_data,
  output logic                    busy,
  output logic                    score_valid,
  output logic [3:0]              score_class,
  output logic [ACC_W-1:0]        score,
  output logic                    done,
  output logic [3:0]              class_idx,
  output logic [ACC_W-1:0]        best_score
);

  localparam logic [FA_W-1:0] K_LAST   = FA_W'(N_FEAT - 1);
  localparam logic [3:0]      CLS_LAST = 4'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cls_q, cls_d;
  logic [FA_W-1:0]          k_q, k_d;
  logic [FA_W-1:0]          f_addr_q, f_addr_d;
  logic [WA_W-1:0]          w_addr_q, w_addr_d;
  logic [3:0]               b_addr_q, b_addr_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     score_valid_q, score_valid_d;
  logic [3:0]               score_class_q, score_class_d;
  logic signed [ACC_W-1:0]  score_q, score_d;
  logic                     done_q, done_d;
  logic [3:0]               class_idx_q, class_idx_d;
  logic signed [ACC_W-1:0]  best_score_q, best_score_d;
  // Read-data tracking: vld_q marks that this cycle carries memory data for
  // an address issued last cycle; first_q marks that it is element 0, whose
  // accumulation starts from the bias instead of the running sum.
  logic                     vld_q, vld_d;
  logic                     first_q, first_d;

  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_sum;

  // --------------------------------------------------------------------------
  // Datapath: product and accumulate
  // --------------------------------------------------------------------------
  always_comb begin
    prod     = $signed(f_data) * $signed(w_data);
    bias_ext = ACC_W'($signed(b_data));
    acc_base = first_q ? bias_ext : acc_q;
  end

`ifdef FC_SAT_EN
  // The add is done wide enough to hold any ACC_W + 16-bit sum, so overflow
  // is detected exactly even when ACC_W is narrower than the product.
  localparam int SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [SUM_W-1:0] sum_wide;

  always_comb begin
    sum_wide = SUM_W'(acc_base) + SUM_W'(prod);
    if (sum_wide > SAT_MAX) begin
      acc_sum = SAT_MAX[ACC_W-1:0];
    end else if (sum_wide < SAT_MIN) begin
      acc_sum = SAT_MIN[ACC_W-1:0];
    end else begin
      acc_sum = sum_wide[ACC_W-1:0];
    end
  end
`else
  // Plain two's-complement wrap; the product is sign-extended (or truncated,
  // which is equivalent modulo 2**ACC_W) to the accumulator width.
  always_comb begin
    acc_sum = acc_base + ACC_W'(prod);
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    k_d           = k_q;
    f_addr_d      = f_addr_q;
    w_addr_d      = w_addr_q;
    b_addr_d      = b_addr_q;
    acc_d         = acc_q;
    busy_d        = busy_q;
    score_valid_d = 1'b0;
    score_class_d = score_class_q;
    score_d       = score_q;
    done_d        = 1'b0;
    class_idx_d   = class_idx_q;
    best_score_d  = best_score_q;
    vld_d         = 1'b0;
    first_d       = 1'b0;

    if (vld_q) begin
      acc_d = acc_sum;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          cls_d    = 4'd0;
          k_d      = '0;
          busy_d   = 1'b1;
          f_addr_d = '0;
          w_addr_d = '0;
          b_addr_d = 4'd0;
          state_d  = MAC;
        end
      end

      // Addresses are registered one cycle ahead, so the address for element
      // k is already on the memory port during the MAC cycle with k_q == k.
      MAC: begin
        vld_d   = 1'b1;
        first_d = (k_q == '0);
        if (k_q == K_LAST) begin
          state_d = EVAL;
        end else begin
          k_d      = k_q + 1'b1;
          f_addr_d = k_q + 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end

      // The last product is returning; acc_sum is the finished class score.
      EVAL: begin
        score_d       = acc_sum;
        score_class_d = cls_q;
        score_valid_d = 1'b1;
        if ((cls_q == 4'd0) || (acc_sum > best_score_q)) begin
          best_score_d = acc_sum;
          class_idx_d  = cls_q;
        end
        if (cls_q != CLS_LAST) begin
          cls_d    = cls_q + 4'd1;
          k_d      = '0;
          f_addr_d = '0;
          // Weight rows are contiguous: the next class starts right after
          // the last weight of this class.
          w_addr_d = w_addr_q + 1'b1;
          b_addr_d = cls_q + 4'd1;
          state_d  = MAC;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cls_q         <= 4'd0;
      k_q           <= '0;
      f_addr_q      <= '0;
      w_addr_q      <= '0;
      b_addr_q      <= 4'd0;
      acc_q         <= '0;
      busy_q        <= 1'b0;
      score_valid_q <= 1'b0;
      score_class_q <= 4'd0;
      score_q       <= '0;
      done_q        <= 1'b0;
      class_idx_q   <= 4'd0;
      best_score_q  <= '0;
      vld_q         <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      k_q           <= k_d;
      f_addr_q      <= f_addr_d;
      w_addr_q      <= w_addr_d;
      b_addr_q      <= b_addr_d;
      acc_q         <= acc_d;
      busy_q        <= busy_d;
      score_valid_q <= score_valid_d;
      score_class_q <= score_class_d;
      score_q       <= score_d;
      done_q        <= done_d;
      class_idx_q   <= class_idx_d;
      best_score_q  <= best_score_d;
      vld_q         <= vld_d;
      first_q       <= first_d;
    end
  end

  assign f_addr      = f_addr_q;
  assign w_addr      = w_addr_q;
  assign b_addr      = b_addr_q;
  assign busy        = busy_q;
  assign score_valid = score_valid_q;
  assign score_class = score_class_q;
  assign score       = score_q;
  assign done        = done_q;
  assign class_idx   = class_idx_q;
  assign best_score  = best_score_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_classifier
// Description : Directed testbench for fc_classifier with N_FEAT=4,
//               NUM_CLASSES=3, ACC_W=12. Models the feature, weight and bias
//               memories as synchronous 1-cycle-latency ROMs. Expected scores
//               are hand computed. Honours FC_SAT_EN for the overflow case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_classifier;

  localparam int N_FEAT      = 4;
  localparam int NUM_CLASSES = 3;
  localparam int ACC_W       = 12;
  localparam int FA_W        = 3;
  localparam int WA_W        = 4;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [FA_W-1:0]         f_addr;
  logic [7:0]              f_data;
  logic [WA_W-1:0]         w_addr;
  logic [7:0]              w_data;
  logic [3:0]              b_addr;
  logic [7:0]              b_data;
  logic                    busy;
  logic                    score_valid;
  logic [3:0]              score_class;
  logic signed [ACC_W-1:0] score;
  logic                    done;
  logic [3:0]              class_idx;
  logic signed [ACC_W-1:0] best_score;

  logic [7:0] feat [8];
  logic [7:0] wgt  [16];
  logic [7:0] bias [16];

  int n_checks;
  int n_pass;

  fc_classifier #(
    .N_FEAT      (N_FEAT),
    .NUM_CLASSES (NUM_CLASSES),
    .ACC_W       (ACC_W),
    .FA_W        (FA_W),
    .WA_W        (WA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .f_addr      (f_addr),
    .f_data      (f_data),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .busy        (busy),
    .score_valid (score_valid),
    .score_class (score_class),
    .score       (score),
    .done        (done),
    .class_idx   (class_idx),
    .best_score  (best_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs, 1-cycle read latency
  always @(posedge clk) begin
    f_data <= feat[f_addr];
    w_data <= wgt[w_addr];
    b_data <= bias[b_addr];
  end

  // Load features and per-class weights/biases (weights row-major by class)
  task automatic load_mem(input logic signed [7:0] f0, f1, f2, f3,
                          input logic signed [7:0] a0, a1, a2, a3,
                          input logic signed [7:0] c0, c1, c2, c3,
                          input logic signed [7:0] d0, d1, d2, d3,
                          input logic signed [7:0] b0, b1, b2);
    for (int i = 0; i < 8; i++)  feat[i] = 8'd0;
    for (int i = 0; i < 16; i++) begin
      wgt[i]  = 8'd0;
      bias[i] = 8'd0;
    end
    feat[0] = f0; feat[1] = f1; feat[2] = f2; feat[3] = f3;
    wgt[0]  = a0; wgt[1]  = a1; wgt[2]  = a2; wgt[3]  = a3;
    wgt[4]  = c0; wgt[5]  = c1; wgt[6]  = c2; wgt[7]  = c3;
    wgt[8]  = d0; wgt[9]  = d1; wgt[10] = d2; wgt[11] = d3;
    bias[0] = b0; bias[1] = b1; bias[2] = b2;
  endtask

  // One complete classification. chained=1: start is already high in the
  // current cycle (set at the previous done). chain_next=1: raise start in
  // the done cycle so the next run is accepted immediately.
  task automatic do_run(input string name,
                        input logic signed [ACC_W-1:0] e0, e1, e2,
                        input logic [3:0] eidx,
                        input logic signed [ACC_W-1:0] ebest,
                        input logic [3:0] prev_idx,
                        input bit dup_start,
                        input bit chained,
                        input bit chain_next);
    logic signed [ACC_W-1:0] ev [3];
    int nval;
    bit got_done;
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    nval = 0;
    got_done = 1'b0;
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;

    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    else n_pass++;
    n_checks++;
    if (class_idx !== prev_idx)
      $display("FAIL %s class_idx_held: got %0d expected %0d", name, class_idx, prev_idx);
    else n_pass++;

    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (dup_start) begin
        if (cyc == 3) start = 1'b1;
        if (cyc == 5) start = 1'b0;
      end
      if (score_valid === 1'b1) begin
        if (nval < 3) begin
          n_checks++;
          if (cyc != (nval + 1) * (N_FEAT + 1) + 1)
            $display("FAIL %s score_valid_cycle c%0d: got %0d expected %0d",
                     name, nval, cyc, (nval + 1) * (N_FEAT + 1) + 1);
          else n_pass++;
          n_checks++;
          if (score !== ev[nval])
            $display("FAIL %s score c%0d: got %0d expected %0d", name, nval, score, ev[nval]);
          else n_pass++;
          n_checks++;
          if (score_class !== 4'(nval))
            $display("FAIL %s score_class c%0d: got %0d expected %0d",
                     name, nval, score_class, nval);
          else n_pass++;
        end
        nval++;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        n_checks++;
        if (cyc != NUM_CLASSES * (N_FEAT + 1) + 1)
          $display("FAIL %s done_cycle: got %0d expected %0d",
                   name, cyc, NUM_CLASSES * (N_FEAT + 1) + 1);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
        else n_pass++;
        n_checks++;
        if (class_idx !== eidx)
          $display("FAIL %s class_idx: got %0d expected %0d", name, class_idx, eidx);
        else n_pass++;
        n_checks++;
        if (best_score !== ebest)
          $display("FAIL %s best_score: got %0d expected %0d", name, best_score, ebest);
        else n_pass++;
        if (chain_next) start = 1'b1;
        break;
      end
    end

    n_checks++;
    if (!got_done) $display("FAIL %s done_timeout: got no done expected done within 30 cycles", name);
    else n_pass++;
    n_checks++;
    if (nval != 3) $display("FAIL %s score_count: got %0d expected 3", name, nval);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({f_addr, w_addr, b_addr} !== '0)
      $display("FAIL %s addr: got f=%0d w=%0d b=%0d expected 0", name, f_addr, w_addr, b_addr);
    else n_pass++;
    n_checks++;
    if ({busy, score_valid, done} !== 3'b000)
      $display("FAIL %s flags: got busy=%b sv=%b done=%b expected 0", name, busy, score_valid, done);
    else n_pass++;
    n_checks++;
    if ({score_class, score} !== '0)
      $display("FAIL %s score: got class=%0d score=%0d expected 0", name, score_class, score);
    else n_pass++;
    n_checks++;
    if ({class_idx, best_score} !== '0)
      $display("FAIL %s result: got idx=%0d best=%0d expected 0", name, class_idx, best_score);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_active");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic;
    load_mem(1, 2, 3, 4,  1, 1, 1, 1,  2, 0, 0, 1,  -1, 0, 0, 5,  0, 3, -2);
    do_run("basic", 12'sd10, 12'sd9, 12'sd17, 4'd2, 12'sd17, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Addresses must hold their last issued values once idle.
  task automatic test_idle_hold;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (f_addr !== 3'd3 || w_addr !== 4'd11 || b_addr !== 4'd2)
      $display("FAIL idle_hold: got f=%0d w=%0d b=%0d expected f=3 w=11 b=2", f_addr, w_addr, b_addr);
    else n_pass++;
  endtask

  task automatic test_tie;
    load_mem(1, 2, 3, 4,  1, 1, 1, 1,  0, 0, 0, 1,  1, 0, 0, 1,  -3, 3, 0);
    do_run("tie", 12'sd7, 12'sd7, 12'sd5, 4'd0, 12'sd7, 4'd2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_negative_dup_start;
    load_mem(1, 2, 3, 4,  -1, -1, -1, -1,  0, 0, -1, 0,  0, 0, 0, -2,  -10, 0, -1);
    do_run("negative", -12'sd20, -12'sd3, -12'sd9, 4'd1, -12'sd3, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    logic signed [ACC_W-1:0] e;
`ifdef FC_SAT_EN
    e = 12'sd2047;
`else
    e = -12'sd893;
`endif
    load_mem(127, 127, 127, 127,  127, 127, 127, 127,  127, 127, 127, 127,
             127, 127, 127, 127,  127, 127, 127);
    do_run("overflow", e, e, e, 4'd0, e, 4'd1, 1'b0, 1'b0, 1'b0);
  endtask

  // Start raised in the done cycle is accepted straight away.
  task automatic test_back_to_back;
    load_mem(1, 2, 3, 4,  1, 1, 1, 1,  2, 0, 0, 1,  -1, 0, 0, 5,  0, 3, -2);
    do_run("b2b_first", 12'sd10, 12'sd9, 12'sd17, 4'd2, 12'sd17, 4'd0, 1'b0, 1'b0, 1'b1);
    do_run("b2b_second", 12'sd10, 12'sd9, 12'sd17, 4'd2, 12'sd17, 4'd2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);  // cycle 7: class 1 MAC
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("mid_run_reset");
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) $display("FAIL mid_run_no_done: got done/busy after abort expected none");
    else n_pass++;
    load_mem(1, 2, 3, 4,  1, 1, 1, 1,  2, 0, 0, 1,  -1, 0, 0, 5,  0, 3, -2);
    do_run("after_abort", 12'sd10, 12'sd9, 12'sd17, 4'd2, 12'sd17, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    for (int i = 0; i < 8; i++)  feat[i] = 8'd0;
    for (int i = 0; i < 16; i++) begin
      wgt[i]  = 8'd0;
      bias[i] = 8'd0;
    end
    test_reset();
    test_basic();
    test_idle_hold();
    test_tie();
    test_negative_dup_start();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
